// File: rtl/screensaver_blitter.sv
// screensaver_blitter: raster-scan pixel source for the VGA adapter plot port.
// Sweeps every pixel of the frame, addresses a bank of synchronous image ROMs,
// realigns the coordinates with the ROM read latency and owns the dwell timer
// so the displayed image only ever changes between frames.
module screensaver_blitter #(
  parameter int WIDTH         = 160,
  parameter int HEIGHT        = 120,
  parameter int ADDR_W        = 15,
  parameter int ROM_LATENCY   = 1,
  parameter int NUM_IMAGES    = 3,
  parameter int DWELL_SECONDS = 10
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              second_tick,
  input  logic              enable,
  output logic [ADDR_W-1:0] rom_address,
  input  logic [2:0]        rom0_data,
  input  logic [2:0]        rom1_data,
  input  logic [2:0]        rom2_data,
  output logic [7:0]        x,
  output logic [6:0]        y,
  output logic [2:0]        colour,
  output logic              plot,
  output logic [1:0]        image_sel,
  output logic              frame_done
);

  localparam int DWELL_W = (DWELL_SECONDS > 1) ? $clog2(DWELL_SECONDS) : 1;
  localparam int LAST    = ROM_LATENCY - 1;
  localparam logic [2:0] NUM_IMAGES_L = 3'(NUM_IMAGES);

  logic [7:0]         scan_x_q, scan_x_d;
  logic [6:0]         scan_y_q, scan_y_d;
  logic [DWELL_W-1:0] dwell_cnt_q, dwell_cnt_d;
  logic               pending_q, pending_d;
  logic [1:0]         image_sel_q, image_sel_d;

  logic [7:0] pipe_x_q     [ROM_LATENCY];
  logic [6:0] pipe_y_q     [ROM_LATENCY];
  logic       pipe_valid_q [ROM_LATENCY];
  logic [1:0] pipe_sel_q   [ROM_LATENCY];

  logic [7:0] x_q;
  logic [6:0] y_q;
  logic [2:0] colour_q;
  logic       plot_q;
  logic       frame_done_q;

  logic       at_line_end;
  logic       at_frame_end;
  logic       frame_wrap;
  logic       dwell_complete;
  logic [2:0] aligned_colour;

  assign at_line_end    = (scan_x_q == 8'(WIDTH - 1));
  assign at_frame_end   = at_line_end && (scan_y_q == 7'(HEIGHT - 1));
  assign frame_wrap     = enable && at_frame_end;
  assign dwell_complete = second_tick && (dwell_cnt_q == DWELL_W'(DWELL_SECONDS - 1));

  // Linear ROM address straight from the scan registers (max 19199 fits 15 bits).
  assign rom_address = ADDR_W'(scan_y_q) * ADDR_W'(WIDTH) + ADDR_W'(scan_x_q);

  // Raster scan: advance one pixel per enabled cycle, wrapping lines and frames.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    scan_x_d = scan_x_q;
    scan_y_d = scan_y_q;
    if (enable) begin
      if (at_line_end) begin
        scan_x_d = '0;
        scan_y_d = at_frame_end ? '0 : scan_y_q + 7'd1;
      end else begin
        scan_x_d = scan_x_q + 8'd1;
      end
    end
  end

  // Dwell timer and image select: an advance is queued by the timer and only
  // consumed at a frame wrap, so a frame never mixes two images.
  always_comb begin
    dwell_cnt_d = dwell_cnt_q;
    pending_d   = pending_q;
    image_sel_d = image_sel_q;
    if (second_tick) begin
      dwell_cnt_d = dwell_complete ? '0 : dwell_cnt_q + DWELL_W'(1);
    end
    if (frame_wrap && (pending_q || dwell_complete)) begin
      image_sel_d = (image_sel_q == 2'(NUM_IMAGES - 1)) ? 2'd0 : image_sel_q + 2'd1;
      pending_d   = 1'b0;
    end else if (dwell_complete) begin
      pending_d = 1'b1;
    end
  end

  // Scan, dwell and select state registers.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      scan_x_q    <= '0;
      scan_y_q    <= '0;
      dwell_cnt_q <= '0;
      pending_q   <= 1'b0;
      image_sel_q <= '0;
    end else begin
      // NOTE: sequential state uses <= so every flop samples the pre-edge values.
      scan_x_q    <= scan_x_d;
      scan_y_q    <= scan_y_d;
      dwell_cnt_q <= dwell_cnt_d;
      pending_q   <= pending_d;
      image_sel_q <= image_sel_d;
    end
  end

  // Delay line carrying the pixel's coordinates, valid and image select
  // alongside the ROM read so they arrive together with the ROM data.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      // NOTE: these arrays are a few flops, not RAM, so resetting every entry is cheap and keeps outputs clean.
      for (int i = 0; i < ROM_LATENCY; i++) begin
        pipe_x_q[i]     <= '0;
        pipe_y_q[i]     <= '0;
        pipe_valid_q[i] <= 1'b0;
        pipe_sel_q[i]   <= '0;
      end
    end else begin
      pipe_x_q[0]     <= scan_x_q;
      pipe_y_q[0]     <= scan_y_q;
      pipe_valid_q[0] <= enable;
      pipe_sel_q[0]   <= image_sel_q;
      for (int i = 1; i < ROM_LATENCY; i++) begin
        pipe_x_q[i]     <= pipe_x_q[i-1];
        pipe_y_q[i]     <= pipe_y_q[i-1];
        pipe_valid_q[i] <= pipe_valid_q[i-1];
        pipe_sel_q[i]   <= pipe_sel_q[i-1];
      end
    end
  end

  // Pick the ROM matching the delayed select; unused selects read as black.
  always_comb begin
    aligned_colour = 3'b000;
    if ({1'b0, pipe_sel_q[LAST]} < NUM_IMAGES_L) begin
      case (pipe_sel_q[LAST])
        2'd0:    aligned_colour = rom0_data;
        2'd1:    aligned_colour = rom1_data;
        2'd2:    aligned_colour = rom2_data;
        default: aligned_colour = 3'b000;
      endcase
    end
  end

  // Output register; idle cycles keep the last plotted pixel on x/y/colour.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      x_q          <= '0;
      y_q          <= '0;
      colour_q     <= '0;
      plot_q       <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      plot_q       <= pipe_valid_q[LAST];
      frame_done_q <= pipe_valid_q[LAST]
                      && (pipe_x_q[LAST] == 8'(WIDTH - 1))
                      && (pipe_y_q[LAST] == 7'(HEIGHT - 1));
      if (pipe_valid_q[LAST]) begin
        x_q      <= pipe_x_q[LAST];
        y_q      <= pipe_y_q[LAST];
        colour_q <= aligned_colour;
      end
    end
  end

  assign x          = x_q;
  assign y          = y_q;
  assign colour     = colour_q;
  assign plot       = plot_q;
  assign image_sel  = image_sel_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_screensaver_blitter.sv
// Bench for screensaver_blitter: a full-size instance (160x120, ROM latency 1)
// and a small-frame instance (8x4, ROM latency 2) run one after the other
// against a behavioural scan/dwell model feeding an expected-pixel queue.
module tb_screensaver_blitter;

  localparam int DWELL = 10;
  localparam int NIMG  = 3;

  typedef struct {
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] colour;
    logic       fd;
    int         due;
  } exp_t;

  typedef struct {
    int         cyc;
    logic       en;
    logic       plot;
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] colour;
    logic       fd;
  } vec_t;

  logic clock = 1'b0;
  logic resetn_a, resetn_b, enable, second_tick, use_b;

  logic [14:0] addr_a, addr_b, addr_a_q, addr_b_q1, addr_b_q2;
  logic [2:0]  rom0_a, rom1_a, rom2_a, rom0_b, rom1_b, rom2_b;
  logic [7:0]  x_a, x_b;
  logic [6:0]  y_a, y_b;
  logic [2:0]  colour_a, colour_b;
  logic        plot_a, plot_b, fd_a, fd_b;
  logic [1:0]  sel_a, sel_b;

  logic [14:0] o_addr;
  logic [7:0]  o_x;
  logic [6:0]  o_y;
  logic [2:0]  o_colour;
  logic        o_plot, o_fd;
  logic [1:0]  o_sel;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // Model state for the instance under test.
  int m_w, m_h, m_lat, m_x, m_y, m_sel, m_cnt;
  logic m_pend;
  exp_t sb[$];
  logic [7:0] last_x;
  logic [6:0] last_y;
  logic [2:0] last_c;
  logic obs_plot;

  always #5 clock = ~clock;

  function automatic logic [2:0] rom_fn(input logic [14:0] addr, input int img);
    case (img)
      0:       return addr[2:0];
      1:       return addr[2:0] ^ 3'd5;
      2:       return addr[2:0] ^ 3'd6;
      default: return 3'd0;
    endcase
  endfunction

  // Synchronous ROM models: latency 1 for instance A, latency 2 for instance B.
  always @(posedge clock) begin
    addr_a_q  <= addr_a;
    addr_b_q1 <= addr_b;
    addr_b_q2 <= addr_b_q1;
  end
  assign rom0_a = rom_fn(addr_a_q, 0);
  assign rom1_a = rom_fn(addr_a_q, 1);
  assign rom2_a = rom_fn(addr_a_q, 2);
  assign rom0_b = rom_fn(addr_b_q2, 0);
  assign rom1_b = rom_fn(addr_b_q2, 1);
  assign rom2_b = rom_fn(addr_b_q2, 2);

  screensaver_blitter dut_a (
    .clock(clock), .resetn(resetn_a), .second_tick(second_tick), .enable(enable),
    .rom_address(addr_a), .rom0_data(rom0_a), .rom1_data(rom1_a), .rom2_data(rom2_a),
    .x(x_a), .y(y_a), .colour(colour_a), .plot(plot_a), .image_sel(sel_a),
    .frame_done(fd_a)
  );

  screensaver_blitter #(.WIDTH(8), .HEIGHT(4), .ROM_LATENCY(2)) dut_b (
    .clock(clock), .resetn(resetn_b), .second_tick(second_tick), .enable(enable),
    .rom_address(addr_b), .rom0_data(rom0_b), .rom1_data(rom1_b), .rom2_data(rom2_b),
    .x(x_b), .y(y_b), .colour(colour_b), .plot(plot_b), .image_sel(sel_b),
    .frame_done(fd_b)
  );

  assign o_addr   = use_b ? addr_b   : addr_a;
  assign o_x      = use_b ? x_b      : x_a;
  assign o_y      = use_b ? y_b      : y_a;
  assign o_colour = use_b ? colour_b : colour_a;
  assign o_plot   = use_b ? plot_b   : plot_a;
  assign o_fd     = use_b ? fd_b     : fd_a;
  assign o_sel    = use_b ? sel_b    : sel_a;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 40)
        $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_reset(input int w, input int h, input int lat);
    m_w = w; m_h = h; m_lat = lat;
    m_x = 0; m_y = 0; m_sel = 0; m_cnt = 0; m_pend = 1'b0;
    sb.delete();
    last_x = '0; last_y = '0; last_c = '0; obs_plot = 1'b0;
    cyc = 0;
  endtask

  // One clock: drive inputs, push the expected pixel, advance the model,
  // then compare the DUT on the following falling edge.
  task automatic step(input logic en, input logic tick);
    exp_t e;
    logic dc, wrap, exp_plot;
    logic [14:0] a;
    enable = en;
    second_tick = tick;
    if (en) begin
      a = 15'(m_y * m_w + m_x);
      e.x = 8'(m_x);
      e.y = 7'(m_y);
      e.colour = rom_fn(a, m_sel);
      e.fd = (m_x == m_w - 1) && (m_y == m_h - 1);
      e.due = cyc + m_lat + 1;
      sb.push_back(e);
    end
    dc = tick && (m_cnt == DWELL - 1);
    if (tick) m_cnt = dc ? 0 : m_cnt + 1;
    wrap = en && (m_x == m_w - 1) && (m_y == m_h - 1);
    if (wrap && (m_pend || dc)) begin
      m_sel = (m_sel == NIMG - 1) ? 0 : m_sel + 1;
      m_pend = 1'b0;
    end else if (dc) begin
      m_pend = 1'b1;
    end
    if (en) begin
      if (m_x == m_w - 1) begin
        m_x = 0;
        m_y = (m_y == m_h - 1) ? 0 : m_y + 1;
      end else begin
        m_x = m_x + 1;
      end
    end
    @(posedge clock);
    cyc++;
    @(negedge clock);
    exp_plot = (sb.size() > 0) && (sb[0].due == cyc);
    check("plot", o_plot, exp_plot);
    check("image_sel", o_sel, m_sel);
    check("rom_address", o_addr, m_y * m_w + m_x);
    if (o_plot && sb.size() > 0) begin
      e = sb.pop_front();
      check("x", o_x, e.x);
      check("y", o_y, e.y);
      check("colour", o_colour, e.colour);
      check("frame_done", o_fd, e.fd);
      last_x = e.x; last_y = e.y; last_c = e.colour;
    end else if (!o_plot) begin
      check("x_hold", o_x, last_x);
      check("y_hold", o_y, last_y);
      check("colour_hold", o_colour, last_c);
      check("frame_done_idle", o_fd, 0);
    end
    obs_plot = o_plot;
  endtask

  task automatic run(input int n, input logic en, input int period, input int ticks);
    int sent;
    logic t;
    sent = 0;
    for (int i = 0; i < n; i++) begin
      t = (sent < ticks) && (i % period == 0);
      if (t) sent++;
      step(en, t);
    end
  endtask

  task automatic run_to(input int tx, input int ty);
    int guard;
    guard = 0;
    while (!(m_x == tx && m_y == ty) && guard < 40000) begin
      step(1'b1, 1'b0);
      guard++;
    end
    check("run_to_reached", (m_x == tx) && (m_y == ty), 1);
  endtask

  // Run to the last pixel and take the frame-wrap edge, optionally with a tick.
  task automatic wrap_step(input logic tick);
    run_to(m_w - 1, m_h - 1);
    step(1'b1, tick);
  endtask

  task automatic run_until_plotted(input int px, input int py);
    int guard;
    guard = 0;
    while (!(obs_plot && last_x == 8'(px) && last_y == 7'(py)) && guard < 40000) begin
      step(1'b1, 1'b0);
      guard++;
    end
    check("plotted_target", obs_plot && (last_x == 8'(px)) && (last_y == 7'(py)), 1);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_x"}, o_x, 0);
    check({tag, "_y"}, o_y, 0);
    check({tag, "_colour"}, o_colour, 0);
    check({tag, "_plot"}, o_plot, 0);
    check({tag, "_frame_done"}, o_fd, 0);
    check({tag, "_image_sel"}, o_sel, 0);
    check({tag, "_rom_address"}, o_addr, 0);
  endtask

  // Assert reset mid-cycle, expect cleared outputs with no clock edge, release on a falling edge.
  task automatic reset_mid(input string tag, input int w, input int h, input int lat);
    if (use_b) resetn_b = 1'b0; else resetn_a = 1'b0;
    #1;
    check_all_zero(tag);
    @(posedge clock);
    @(negedge clock);
    model_reset(w, h, lat);
    if (use_b) resetn_b = 1'b1; else resetn_a = 1'b1;
  endtask

  vec_t vecs[6];
  int   low_cnt;

  initial begin
    vecs[0] = '{cyc: 1,     en: 1'b1, plot: 1'b0, x: 8'd0,   y: 7'd0,   colour: 3'd0, fd: 1'b0};
    vecs[1] = '{cyc: 2,     en: 1'b1, plot: 1'b1, x: 8'd0,   y: 7'd0,   colour: 3'd0, fd: 1'b0};
    vecs[2] = '{cyc: 7,     en: 1'b1, plot: 1'b1, x: 8'd5,   y: 7'd0,   colour: 3'd5, fd: 1'b0};
    vecs[3] = '{cyc: 162,   en: 1'b1, plot: 1'b1, x: 8'd0,   y: 7'd1,   colour: 3'd0, fd: 1'b0};
    vecs[4] = '{cyc: 19201, en: 1'b1, plot: 1'b1, x: 8'd159, y: 7'd119, colour: 3'd7, fd: 1'b1};
    vecs[5] = '{cyc: 19202, en: 1'b1, plot: 1'b1, x: 8'd0,   y: 7'd0,   colour: 3'd5, fd: 1'b0};

    resetn_a = 1'b0; resetn_b = 1'b0; use_b = 1'b0;
    enable = 1'b0; second_tick = 1'b0;
    repeat (3) @(negedge clock);
    check_all_zero("a_reset");

    // ---- Instance A: 160x120, ROM latency 1 ----
    model_reset(160, 120, 1);
    resetn_a = 1'b1;

    // Frame 0 with ten dwell ticks mid-frame; the switch to image 1 shows in vecs[5].
    foreach (vecs[i]) begin
      while (cyc < vecs[i].cyc)
        step(vecs[i].en, (cyc >= 1000) && (cyc < 2000) && (cyc % 100 == 0));
      check($sformatf("vec%0d_plot", i), o_plot, vecs[i].plot);
      check($sformatf("vec%0d_x", i), o_x, vecs[i].x);
      check($sformatf("vec%0d_y", i), o_y, vecs[i].y);
      check($sformatf("vec%0d_colour", i), o_colour, vecs[i].colour);
      check($sformatf("vec%0d_frame_done", i), o_fd, vecs[i].fd);
    end
    check("a_sel_frame1", o_sel, 1);

    // Seven-cycle enable drop at scan_x=50: exactly seven idle plot cycles.
    run_to(50, 10);
    low_cnt = 0;
    for (int i = 0; i < 7; i++) begin
      step(1'b0, 1'b0);
      if (!obs_plot) low_cnt++;
    end
    for (int i = 0; i < m_lat + 4; i++) begin
      step(1'b1, 1'b0);
      if (!obs_plot) low_cnt++;
    end
    check("stall_plot_low_cycles", low_cnt, 7);

    // Ten more ticks in frame 1: image 2 from the next wrap.
    run(200, 1'b1, 20, 10);
    check("a_sel_before_wrap1", o_sel, 1);
    wrap_step(1'b0);
    check("a_sel_after_wrap1", o_sel, 2);

    // Reset while (80,60) of an image-2 frame is on the outputs.
    run_until_plotted(80, 60);
    check("a_sel_before_reset", o_sel, 2);
    reset_mid("a_midreset", 160, 120, 1);
    run(2, 1'b1, 1, 0);
    check("a_restart_plot", o_plot, 1);
    check("a_restart_x", o_x, 0);
    check("a_restart_y", o_y, 0);
    check("a_restart_sel", o_sel, 0);
    run(20, 1'b1, 1, 0);
    resetn_a = 1'b0;

    // ---- Instance B: 8x4, ROM latency 2 ----
    use_b = 1'b1;
    @(negedge clock);
    check_all_zero("b_reset");
    model_reset(8, 4, 2);
    resetn_b = 1'b1;
    run(2, 1'b1, 1, 0);
    check("b_no_plot_cycle2", o_plot, 0);
    run(1, 1'b1, 1, 0);
    check("b_first_plot_cycle3", o_plot, 1);

    // Nine ticks mid-frame, the tenth on the wrap edge itself.
    run(9, 1'b1, 1, 9);
    wrap_step(1'b1);
    check("b_sel_tick_on_wrap", o_sel, 1);
    // Dwell count restarted at 0: nine ticks do not complete, the tenth does.
    run(9, 1'b1, 1, 9);
    wrap_step(1'b0);
    check("b_sel_after_9_ticks", o_sel, 1);
    run(1, 1'b1, 1, 1);
    wrap_step(1'b0);
    check("b_sel_1_to_2", o_sel, 2);
    run(10, 1'b1, 1, 10);
    wrap_step(1'b0);
    check("b_sel_2_to_0", o_sel, 0);

    // 25 ticks with the scan stalled: one queued advance, count left at 5.
    run(50, 1'b0, 2, 25);
    check("b_sel_held_while_stalled", o_sel, 0);
    wrap_step(1'b0);
    check("b_sel_single_advance", o_sel, 1);
    wrap_step(1'b0);
    check("b_sel_no_second_advance", o_sel, 1);
    run(4, 1'b1, 1, 4);
    wrap_step(1'b0);
    check("b_sel_count_was_5", o_sel, 1);
    run(1, 1'b1, 1, 1);
    wrap_step(1'b0);
    check("b_sel_after_count_10", o_sel, 2);

    // Reset mid-frame with latency 2: first plot three cycles after release.
    run_until_plotted(3, 2);
    check("b_sel_before_reset", o_sel, 2);
    reset_mid("b_midreset", 8, 4, 2);
    run(2, 1'b1, 1, 0);
    check("b_restart_no_plot", o_plot, 0);
    run(1, 1'b1, 1, 0);
    check("b_restart_plot", o_plot, 1);
    check("b_restart_x", o_x, 0);
    check("b_restart_y", o_y, 0);
    check("b_restart_sel", o_sel, 0);
    run(40, 1'b1, 1, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/screensaver_blitter.md
Name: screensaver_blitter

Overview:
- Raster-scan pixel source that sits directly upstream of the VGA adapter's plot port.
- Sweeps every pixel of the 160x120 frame, addresses one of NUM_IMAGES synchronous image ROMs, and realigns the coordinates with the ROM read latency.
- Drives x/y/colour/plot to the adapter.
- Owns the screensaver dwell timer, so image changes occur only at frame boundaries and no frame ever shows mixed images.

Parameters:
- WIDTH, 160, pixels per line.
- HEIGHT, 120, lines per frame.
- ADDR_W, 15, ROM address width.
- ROM_LATENCY, 1, clock cycles from ROM address to ROM data (1..3 supported).
- NUM_IMAGES, 3, number of images cycled.
- DWELL_SECONDS, 10, second_tick pulses per image.

Ports:
- clock  in  1  system clock.
- resetn  in  1  asynchronous active-low reset.
- second_tick  in  1  one-cycle pulse, once per second.
- enable  in  1  scan advance enable.
- rom_address  out  ADDR_W  shared address to all image ROMs.
- rom0_data  in  3  image 0 colour {R,G,B}.
- rom1_data  in  3  image 1 colour.
- rom2_data  in  3  image 2 colour.
- x  out  8  plot column.
- y  out  7  plot row.
- colour  out  3  plot colour.
- plot  out  1  write strobe to adapter.
- image_sel  out  2  image currently being scanned.
- frame_done  out  1  pulse with last pixel's plot.

Behaviour:
- Reset: asynchronous on resetn low; cleared values on release are:
  - scan_x=0, scan_y=0, rom_address=0;
  - all pipeline valid bits 0;
  - x=0, y=0, colour=0, plot=0, frame_done=0, image_sel=0;
  - dwell counter 0, pending_advance 0.
- Reset mid-frame: the frame is abandoned and the scan restarts at (0,0) with image 0.
- Scan counters:
  - On a clock edge with enable=1, scan_x increments.
  - At scan_x=WIDTH-1 it wraps to 0 and scan_y increments.
  - At (WIDTH-1, HEIGHT-1) both wrap to 0; this is the frame wrap.
  - With enable=0, scan_x/scan_y hold.
- rom_address = scan_y*WIDTH + scan_x, combinational from the scan registers. Maximum value 19199; no truncation in ADDR_W.
- Pipeline:
  - {scan_x, scan_y, enable-as-valid, image_sel} is delayed ROM_LATENCY stages, aligned with ROM data.
  - Colour is muxed by the delayed select; select >= NUM_IMAGES gives colour 0.
  - The aligned stage is registered into the outputs.
  - Result: plot=1 with the matching x/y/colour exactly ROM_LATENCY+1 cycles after the cycle the pixel's address was driven.
  - plot=0 outputs carry the last plotted x/y/colour unchanged.
- enable deassert: the pipeline keeps draining. In-flight pixels are still plotted; then plot=0 until enable returns. Every pixel is plotted exactly once per frame, in raster order; no skips, no duplicates.
- frame_done: 1 in the same cycle as plot for pixel (WIDTH-1, HEIGHT-1), else 0.
- Dwell counter:
  - Counts second_tick pulses regardless of enable.
  - dwell_complete = second_tick & (count==DWELL_SECONDS-1); on dwell_complete the count clears to 0.
  - On dwell_complete, pending_advance is set; it saturates, so multiple completions before a wrap queue only one advance.
- Image advance:
  - On a frame-wrap edge with (pending_advance | dwell_complete), image_sel increments, wrapping NUM_IMAGES-1 -> 0, and pending_advance clears.
  - A dwell completing on the wrap edge itself takes effect for the new frame.
  - image_sel never changes except at a frame wrap.

Test Plan:
- Reset release, enable=1, ROM model data=address[2:0] for all ROMs, ROM_LATENCY=1 -> plot first high 2 cycles after release with (0,0,colour 0); pixel (5,0) colour 5; pixel (0,1) colour 0 (address 160); frame_done with (159,119) 19201 cycles after release; next plot is (0,0).
- 10 second_ticks delivered mid-frame 0 -> image_sel stays 0 through (159,119), becomes 1 at the wrap; 20 more ticks spanning later frames -> image_sel 2 then 0, each change only at a wrap.
- Drop enable for 7 cycles while scan_x=50 -> plot low for exactly 7 cycles after the pipeline drains; plotted coordinate sequence contiguous (49,50,51,...) with no repeats.
- 10th tick asserted on the same edge as the frame wrap -> the new frame starts with image_sel=1 and dwell count is 0.
- Hold enable=0 while 25 ticks arrive, then enable=1 -> exactly one advance at the next wrap (0->1); dwell count is 5.
- Assert resetn low while plotting (80,60) with image_sel=2 -> all outputs 0 immediately without a clock edge; after release the scan restarts at (0,0) with image 0. Repeat with ROM_LATENCY=2 -> first plot 3 cycles after release.
